// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_e : fetch FSM states (IDLE, REQ, HOLD, DISCARD)
//   XLEN          : instruction / address width
//   PC_STEP_BYTES : default sequential PC increment
//   align_pc()    : clears the two low bits of a redirect target
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP_BYTES = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_adder.sv
// The core's two-input 32-bit adder; carry out is discarded.
//   a_i, b_i : operands
//   sum_o    : a_i + b_i modulo 2^32
module fetch_unit_adder
    import fetch_unit_pkg::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from instruction memory over
// a req/ack handshake, and hands each instruction (with PC and PC+step) to
// decode over valid/ready. Redirects from downstream retarget the fetch.
//   CLK, RESET              : clock, synchronous active-high reset
//   IMEM_REQ/ADDR/ACK/RDATA : instruction memory handshake
//   REDIRECT, REDIRECT_PC   : branch/jump redirect pulse and target
//   OUT_VALID/READY         : decode handshake
//   OUT_INSTR/PC/PC_PLUS4   : delivered instruction and its addresses
//   MISALIGN                : pulse, previous-cycle redirect target was unaligned
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = PC_STEP_BYTES
) (
    input  logic             CLK,
    input  logic             RESET,
    output logic             IMEM_REQ,
    output logic [XLEN-1:0]  IMEM_ADDR,
    input  logic             IMEM_ACK,
    input  logic [XLEN-1:0]  IMEM_RDATA,
    input  logic             REDIRECT,
    input  logic [XLEN-1:0]  REDIRECT_PC,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [XLEN-1:0]  OUT_INSTR,
    output logic [XLEN-1:0]  OUT_PC,
    output logic [XLEN-1:0]  OUT_PC_PLUS4,
    output logic             MISALIGN
);

    localparam logic [XLEN-1:0] RESET_PC_NEXT = RESET_PC + PC_STEP;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] opc_q, opc_d;
    logic [XLEN-1:0] opc4_q, opc4_d;
    logic            misalign_q, misalign_d;

    logic [XLEN-1:0] pc_plus_step;
    logic [XLEN-1:0] redir_tgt;

    fetch_unit_adder u_pc_adder (
        .a_i   (pc_q),
        .b_i   (PC_STEP),
        .sum_o (pc_plus_step)
    );

    assign redir_tgt = align_pc(REDIRECT_PC);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        instr_d    = instr_q;
        opc_d      = opc_q;
        opc4_d     = opc4_q;
        misalign_d = REDIRECT && (REDIRECT_PC[1:0] != 2'b00) && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: state_d = ST_REQ;

            ST_REQ: begin
                if (REDIRECT) begin
                    if (IMEM_ACK) begin
                        // Response lands with the redirect: drop it and refetch.
                        pc_d = redir_tgt;
                    end else begin
                        // Request is still in flight; park the target until it drains.
                        tgt_d   = redir_tgt;
                        state_d = ST_DISCARD;
                    end
                end else if (IMEM_ACK) begin
                    instr_d = IMEM_RDATA;
                    opc_d   = pc_q;
                    opc4_d  = pc_plus_step;
                    pc_d    = pc_plus_step;
                    state_d = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (REDIRECT) begin
                    pc_d    = redir_tgt;
                    state_d = ST_REQ;
                end else if (OUT_READY) begin
                    state_d = ST_REQ;
                end
            end

            ST_DISCARD: begin
                if (REDIRECT) begin
                    tgt_d = redir_tgt;
                end
                if (IMEM_ACK) begin
                    // Latest redirect wins, even one arriving with the ack.
                    pc_d    = REDIRECT ? redir_tgt : tgt_q;
                    state_d = ST_REQ;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            tgt_q      <= RESET_PC;
            instr_q    <= '0;
            opc_q      <= RESET_PC;
            opc4_q     <= RESET_PC_NEXT;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            instr_q    <= instr_d;
            opc_q      <= opc_d;
            opc4_q     <= opc4_d;
            misalign_q <= misalign_d;
        end
    end

    assign IMEM_REQ     = (state_q == ST_REQ) || (state_q == ST_DISCARD);
    assign IMEM_ADDR    = pc_q;
    // Deliberate combinational path: a same-cycle redirect squashes the handoff.
    assign OUT_VALID    = (state_q == ST_HOLD) && !REDIRECT;
    assign OUT_INSTR    = instr_q;
    assign OUT_PC       = opc_q;
    assign OUT_PC_PLUS4 = opc4_q;
    assign MISALIGN     = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        CLK;
    logic        RESET;
    logic        IMEM_REQ, IMEM_ACK;
    logic [31:0] IMEM_ADDR, IMEM_RDATA;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        OUT_VALID, OUT_READY;
    logic [31:0] OUT_INSTR, OUT_PC, OUT_PC_PLUS4;
    logic        MISALIGN;

    // second instance with wrap-around reset PC
    logic        IMEM_REQ2, IMEM_ACK2;
    logic [31:0] IMEM_ADDR2, IMEM_RDATA2;
    logic        OUT_VALID2, OUT_READY2;
    logic [31:0] OUT_INSTR2, OUT_PC2, OUT_PC_PLUS42;
    logic        MISALIGN2;
    logic        REDIRECT2;
    logic [31:0] REDIRECT_PC2;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] sb[$];
    int          ack_lat  = 0;
    int          wait_cnt = 0;
    int          cyc      = 0;
    int          last_acc = -1;
    bit          gap_chk  = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .CLK(CLK), .RESET(RESET),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA),
        .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_INSTR(OUT_INSTR),
        .OUT_PC(OUT_PC), .OUT_PC_PLUS4(OUT_PC_PLUS4), .MISALIGN(MISALIGN)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut2 (
        .CLK(CLK), .RESET(RESET),
        .IMEM_REQ(IMEM_REQ2), .IMEM_ADDR(IMEM_ADDR2), .IMEM_ACK(IMEM_ACK2), .IMEM_RDATA(IMEM_RDATA2),
        .REDIRECT(REDIRECT2), .REDIRECT_PC(REDIRECT_PC2),
        .OUT_VALID(OUT_VALID2), .OUT_READY(OUT_READY2), .OUT_INSTR(OUT_INSTR2),
        .OUT_PC(OUT_PC2), .OUT_PC_PLUS4(OUT_PC_PLUS42), .MISALIGN(MISALIGN2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // memory model: ack after ack_lat cycles of request
    assign IMEM_ACK    = IMEM_REQ && (wait_cnt >= ack_lat);
    assign IMEM_RDATA  = mem_word(IMEM_ADDR);
    assign IMEM_ACK2   = IMEM_REQ2;
    assign IMEM_RDATA2 = mem_word(IMEM_ADDR2);
    assign REDIRECT2    = 1'b0;
    assign REDIRECT_PC2 = '0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (RESET || !IMEM_REQ || IMEM_ACK) wait_cnt <= 0;
        else                                wait_cnt <= wait_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // scoreboard: every accepted instruction must match the next planned PC
    always @(negedge CLK) begin
        if (!RESET && OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_accept", 32'(sb.size()), 32'd1);
            end else begin
                logic [31:0] pc;
                pc = sb.pop_front();
                check_eq("out_pc", OUT_PC, pc);
                check_eq("out_instr", OUT_INSTR, mem_word(pc));
                check_eq("out_pc_plus4", OUT_PC_PLUS4, pc + 32'd4);
            end
            if (gap_chk && last_acc >= 0)
                check_eq("throughput_gap", 32'(cyc - last_acc), 32'd2);
            last_acc = cyc;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check_eq("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        CLK = 0; RESET = 1; REDIRECT = 0; REDIRECT_PC = '0;
        OUT_READY = 0; OUT_READY2 = 0;
        tick(); tick();

        // reset state
        check_eq("rst_req", 32'(IMEM_REQ), 32'd0);
        check_eq("rst_addr", IMEM_ADDR, 32'h0);
        check_eq("rst_valid", 32'(OUT_VALID), 32'd0);
        check_eq("rst_instr", OUT_INSTR, 32'h0);
        check_eq("rst_pc", OUT_PC, 32'h0);
        check_eq("rst_pc4", OUT_PC_PLUS4, 32'h4);
        check_eq("rst_misalign", 32'(MISALIGN), 32'd0);
        check_eq("rst2_pc", OUT_PC2, 32'hFFFF_FFFC);
        check_eq("rst2_pc4", OUT_PC_PLUS42, 32'h0);
        check_eq("rst2_addr", IMEM_ADDR2, 32'hFFFF_FFFC);

        // sequential fetch, same-cycle ack, decode always ready
        for (int unsigned i = 0; i < 4; i++) sb.push_back(32'(i * 4));
        gap_chk = 1; OUT_READY = 1; ack_lat = 0;
        RESET = 0;

        // wrap-around instance
        begin
            int n = 0;
            while (!OUT_VALID2 && n < 20) begin tick(); n++; end
            check_eq("wrap_valid", 32'(OUT_VALID2), 32'd1);
            check_eq("wrap_pc", OUT_PC2, 32'hFFFF_FFFC);
            check_eq("wrap_pc4", OUT_PC_PLUS42, 32'h0);
            check_eq("wrap_instr", OUT_INSTR2, mem_word(32'hFFFF_FFFC));
            OUT_READY2 = 1;
            tick();
            OUT_READY2 = 0;
            check_eq("wrap_next_req", 32'(IMEM_REQ2), 32'd1);
            check_eq("wrap_next_addr", IMEM_ADDR2, 32'h0);
        end
        wait_drain(60);
        gap_chk = 0;

        // backpressure in HOLD
        OUT_READY = 0;
        begin
            int n = 0;
            while (!OUT_VALID && n < 20) begin tick(); n++; end
        end
        for (int unsigned i = 0; i < 5; i++) begin
            check_eq("bp_valid", 32'(OUT_VALID), 32'd1);
            check_eq("bp_pc", OUT_PC, 32'h10);
            check_eq("bp_instr", OUT_INSTR, mem_word(32'h10));
            check_eq("bp_req", 32'(IMEM_REQ), 32'd0);
            tick();
        end
        sb.push_back(32'h10);
        OUT_READY = 1;
        wait_drain(20);

        // redirect in REQ, ack 3 cycles late
        ack_lat = 3;
        sb.push_back(32'h100);
        REDIRECT = 1; REDIRECT_PC = 32'h100;
        check_eq("rq_addr", IMEM_ADDR, 32'h14);
        tick();
        REDIRECT = 0;
        begin
            int n = 0;
            while (!IMEM_ACK && n < 10) begin
                check_eq("disc_req", 32'(IMEM_REQ), 32'd1);
                check_eq("disc_addr", IMEM_ADDR, 32'h14);
                check_eq("disc_valid", 32'(OUT_VALID), 32'd0);
                tick();
                n++;
            end
        end
        check_eq("disc_ack_seen", 32'(IMEM_ACK), 32'd1);
        tick();
        ack_lat = 1;
        check_eq("redir_addr", IMEM_ADDR, 32'h100);
        check_eq("redir_req", 32'(IMEM_REQ), 32'd1);
        wait_drain(20);

        // redirect in HOLD with decode ready the same cycle
        OUT_READY = 0; ack_lat = 0;
        begin
            int n = 0;
            while (!OUT_VALID && n < 20) begin tick(); n++; end
        end
        check_eq("hold_pc_before", OUT_PC, 32'h104);
        sb.push_back(32'h40);
        REDIRECT = 1; REDIRECT_PC = 32'h40; OUT_READY = 1;
        #1;
        check_eq("squash_valid", 32'(OUT_VALID), 32'd0);
        tick();
        REDIRECT = 0;
        wait_drain(20);

        // misaligned redirect target
        sb.push_back(32'h200);
        REDIRECT = 1; REDIRECT_PC = 32'h203;
        check_eq("mis_pre", 32'(MISALIGN), 32'd0);
        tick();
        REDIRECT = 0;
        check_eq("mis_pulse", 32'(MISALIGN), 32'd1);
        check_eq("mis_addr", IMEM_ADDR, 32'h200);
        tick();
        check_eq("mis_clear", 32'(MISALIGN), 32'd0);
        wait_drain(20);

        // reset while in DISCARD
        ack_lat = 5; OUT_READY = 0;
        REDIRECT = 1; REDIRECT_PC = 32'h300;
        tick();
        REDIRECT = 0;
        check_eq("dr_req", 32'(IMEM_REQ), 32'd1);
        check_eq("dr_addr", IMEM_ADDR, 32'h204);
        RESET = 1;
        tick();
        check_eq("dr_rst_req", 32'(IMEM_REQ), 32'd0);
        check_eq("dr_rst_addr", IMEM_ADDR, 32'h0);
        check_eq("dr_rst_valid", 32'(OUT_VALID), 32'd0);
        check_eq("dr_rst_pc", OUT_PC, 32'h0);
        check_eq("dr_rst_instr", OUT_INSTR, 32'h0);
        RESET = 0; ack_lat = 0; OUT_READY = 1;
        sb.push_back(32'h0);
        sb.push_back(32'h4);
        wait_drain(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
